// File: rtl/uart_rx_fifo.sv
// Receive-side character buffer behind the UART receiver: stores {break, data}
// on each receiver valid pulse and presents entries first-word-fall-through.
module uart_rx_fifo #(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned DEPTH        = 16,
  localparam int unsigned CW          = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [PAYLOAD_BITS-1:0] in_data,
  input  logic                    in_break,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_break,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  input  logic                    overflow_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = PAYLOAD_BITS + 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [EW-1:0] w_head;

  // Status decode from the registered occupancy
  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == CW'(0));
  assign count    = r_count;
  assign overflow = r_overflow;

  // A full FIFO still accepts a character when the head leaves the same cycle
  assign w_pop  = !empty && out_ready;
  assign w_push = in_valid && (!full || w_pop);
  assign w_drop = in_valid && full && !w_pop;

  // Head entry, gated to zero while nothing is stored
  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = !empty;
  assign out_data  = empty ? PAYLOAD_BITS'(0) : w_head[PAYLOAD_BITS-1:0];
  assign out_break = empty ? 1'b0 : w_head[PAYLOAD_BITS];

  // Storage array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (resetn && w_push) begin
      r_mem[r_wr_ptr] <= {in_break, in_data};
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios then random traffic,
// checked against a queue-based model of the buffer.
module tb_uart_rx_fifo;

  localparam int unsigned PB    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic [PB-1:0] in_data;
  logic          in_break;
  logic          out_valid;
  logic          out_ready;
  logic [PB-1:0] out_data;
  logic          out_break;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          overflow_clr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PB:0] exp_q[$];
  int          m_count = 0;
  logic        m_ovf   = 1'b0;
  bit          started = 1'b0;

  uart_rx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_break     (in_break),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_break    (out_break),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO occupancy/contents from the acceptance rules, updated per edge
  always @(posedge clk) begin
    bit pop, acc, drop;
    if (!resetn) begin
      m_count = 0;
      exp_q.delete();
      m_ovf   = 1'b0;
      started = 1'b1;
    end else begin
      pop  = (m_count > 0) && out_ready;
      acc  = in_valid && ((m_count < DEPTH) || pop);
      drop = in_valid && !acc;
      if (acc) exp_q.push_back({in_break, in_data});
      m_count = m_count + int'(acc) - int'(pop);
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
    end
  end

  // Monitor: status every cycle, data compared on each accepted handshake
  always @(negedge clk) begin
    logic [PB:0] e;
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(m_count > 0));
      chk("count", 32'(count), 32'(m_count));
      chk("full", 32'(full), 32'(m_count == DEPTH));
      chk("empty", 32'(empty), 32'(m_count == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[PB-1:0]));
          chk("out_break", 32'(out_break), 32'(e[PB]));
        end
      end else if (!out_valid) begin
        chk("idle_data", 32'(out_data), 32'h0);
        chk("idle_break", 32'(out_break), 32'h0);
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge
  task automatic drive(input logic v, input logic [PB-1:0] d, input logic b,
                       input logic r, input logic c, input logic rn);
    in_valid     = v;
    in_data      = d;
    in_break     = b;
    out_ready    = r;
    overflow_clr = c;
    resetn       = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(1'b0, PB'(0), 1'b0, r, 1'b0, 1'b1);
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; in_break = 1'b0;
    out_ready = 1'b0; overflow_clr = 1'b0; resetn = 1'b0;
    drive(1'b0, PB'(0), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, PB'(0), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);

    // Single character in and out
    drive(1'b1, PB'(8'h41), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", 32'(out_data), 32'h41);
    chk("single_count", 32'(count), 32'h1);
    drive(1'b0, PB'(0), 1'b0, 1'b1, 1'b0, 1'b1);
    chk("single_drained", 32'(empty), 32'h1);
    chk("single_zero", 32'(out_data), 32'h0);

    // Fill, drop, clear, pushed-while-popping at full, full drain with wrap
    for (int i = 0; i < DEPTH; i++) drive(1'b1, PB'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'(DEPTH));
    drive(1'b1, PB'(8'hAA), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("drop_ovf", 32'(overflow), 32'h1);
    chk("drop_count", 32'(count), 32'(DEPTH));
    drive(1'b0, PB'(0), 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'h0);
    drive(1'b1, PB'(8'h55), 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pushpop_ovf", 32'(overflow), 32'h0);
    chk("pushpop_count", 32'(count), 32'(DEPTH));
    idle(DEPTH + 2, 1'b1);

    // BREAK tagging
    drive(1'b1, PB'(8'h00), 1'b1, 1'b0, 1'b0, 1'b1);
    chk("brk_tag", 32'(out_break), 32'h1);
    drive(1'b1, PB'(8'h7E), 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Drop coinciding with clear keeps overflow set
    for (int i = 0; i < DEPTH; i++) drive(1'b1, PB'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, PB'(8'hEE), 1'b0, 1'b0, 1'b1, 1'b1);
    chk("drop_and_clr", 32'(overflow), 32'h1);
    idle(DEPTH + 1, 1'b1);

    // Reset mid-stream with a coincident character
    for (int i = 0; i < 5; i++) drive(1'b1, PB'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, PB'(8'h99), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_empty", 32'(empty), 32'h1);
    chk("midrst_ovf", 32'(overflow), 32'h0);
    drive(1'b1, PB'(8'h33), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("after_rst_head", 32'(out_data), 32'h33);
    idle(2, 1'b1);

    // Random traffic: alternating consumer speeds to visit full and empty
    for (int i = 0; i < 3000; i++) begin
      int unsigned rp;
      logic v, r, c, rn;
      rp = ((i / 300) % 2 == 0) ? 25 : 75;
      v  = ($urandom_range(99) < 60);
      r  = ($urandom_range(99) < rp);
      c  = ($urandom_range(99) < 4);
      rn = ($urandom_range(999) != 0);
      drive(v, PB'($urandom), 1'(($urandom_range(9) == 0)), r, c, rn);
    end
    idle(DEPTH + 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each received character, together with its BREAK indication, on the receiver's single-cycle valid pulse. It presents the characters to the system side through a first-word-fall-through valid/ready interface. Characters that arrive while the buffer is full are dropped, and a sticky overflow flag is raised.

## Interface

Parameters:
- PAYLOAD_BITS, 8, data bits per character; must match the receiver.
- DEPTH, 16, number of entries; power of two, ≥ 2.
- CW (localparam), $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- in_valid  input  1  one-cycle pulse from the receiver: a character is complete.
- in_data  input  PAYLOAD_BITS  received character; sampled only when in_valid=1.
- in_break  input  1  BREAK indication accompanying in_data; sampled only when in_valid=1.
- out_valid  output  1  head entry available (FIFO not empty).
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_data  output  PAYLOAD_BITS  head entry data; 0 when out_valid=0.
- out_break  output  1  head entry BREAK tag; 0 when out_valid=0.
- count  output  CW  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: at least one character was dropped since the last clear or reset.
- overflow_clr  input  1  single-cycle clear of overflow.

## Operation

- Storage: DEPTH × (PAYLOAD_BITS+1) array holding {in_break, in_data}. Write pointer and read pointer are each $clog2(DEPTH) bits, with natural wrap from DEPTH-1 to 0. A registered count of CW bits tracks occupancy.
- Push: push = in_valid && (!full || pop).
  - The entry is written at wr_ptr, and wr_ptr advances by 1.
- Pop: pop = out_valid && out_ready.
  - rd_ptr advances by 1.
  - out_ready while empty is ignored; there is no underflow.
- Count update per cycle:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Full with a simultaneous pop: the incoming character is accepted, and count stays at DEPTH.
- Drop: in_valid && full && !pop.
  - The character is discarded; pointers and count are unchanged.
  - overflow is set to 1 on the next edge.
- overflow_clr clears overflow. If a drop and overflow_clr occur in the same cycle, the set wins and overflow stays 1.
- Output path: out_valid = !empty.
  - out_data and out_break are read combinationally from the array at rd_ptr and gated to 0 when empty.
  - They are held stable while out_valid=1 and out_ready=0.
- BREAK characters are stored and delivered like any other entry. in_data of a BREAK entry is stored verbatim and is normally 0.
- Reset (resetn=0 at an edge): rd_ptr=0, wr_ptr=0, count=0, overflow=0. Array contents are not reset.
  - Outputs immediately after reset: out_valid=0, out_data=0, out_break=0, empty=1, full=0, count=0, overflow=0.
  - Reset asserted mid-stream discards all stored entries. An in_valid in the reset cycle is ignored.

## Timing

- Push latency: in_valid sampled at edge N updates count/full/empty after edge N. The entry is visible on out_valid/out_data in the cycle following edge N, with no bubble when the FIFO was empty.
- Pop: the next head entry, or out_valid=0, appears in the cycle after the accepting edge.
- full, empty and count are decoded from registered count. There is no combinational path from in_valid to any output.
- There are combinational paths from out_ready to push only. No output depends combinationally on out_ready.
- Sustained throughput: one push and one pop per cycle.

## Test plan

- Reset, then single push of in_data=0x41, in_break=0 → next cycle out_valid=1, out_data=0x41, count=1. With out_ready=1 for one cycle → out_valid=0, out_data=0, empty=1.
- Push 0x00..0x0F (DEPTH=16) with out_ready=0 → full=1, count=16. Drain with out_ready=1 → values delivered in order 0x00..0x0F, then empty=1.
- With the FIFO full, push 0xAA while out_ready=0 → overflow=1, count=16, and 0xAA is never output. Then pulse overflow_clr → overflow=0.
- With the FIFO full, push 0x55 in the same cycle as a pop → overflow stays 0, count stays 16. 0x55 emerges last after a full drain, which also exercises pointer wrap.
- Push in_data=0x00, in_break=1, then 0x7E with in_break=0 → first entry out_break=1, out_data=0x00; second entry out_break=0. Also: a drop coinciding with overflow_clr leaves overflow=1.
- Fill 5 entries, assert resetn=0 for one cycle together with in_valid → count=0, empty=1, overflow=0. A subsequent push of 0x33 is the first character output.
